pc_fetch_unit: RTL

- Program-counter and fetch-control stage directly upstream of the instruction ROM in the single-cycle RISC-V core.
- Holds the PC, drives it as the ROM byte address, and takes the returned instruction word.
- Selects the next PC from sequential, branch/JAL target or JALR target. Supports stall.
- Detects misaligned control-flow targets and halts with a sticky trap. Counts retired instructions.

---
 rtl/pc_fetch_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch control feeding the instruction ROM of the single-cycle core.
// Chooses the next PC, qualifies the fetched word, traps on bad targets and counts retired instructions.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES   = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic [1:0]  pc_src_i,
    input  logic [31:0] branch_tgt_i,
    input  logic [31:0] jalr_tgt_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        trap_o,
    output logic [1:0]  trap_cause_o,
    output logic [31:0] instret_o,
    output logic [1:0]  state_o
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JALR   = 2'b10;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_OUT_RANGE = 2'b10;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instret;
    logic        r_trap;
    logic [1:0]  r_cause;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jalr_aligned;
    logic [31:0] w_next_pc;
    logic        w_misaligned;
    logic        w_out_range;
    logic        w_advance;
    logic        w_fault;
    logic [1:0]  w_fault_cause;

    assign w_pc_plus4     = r_pc + 32'd4;
    // JALR clears bit 0 of rs1+imm before use as a target.
    assign w_jalr_aligned = jalr_tgt_i & ~32'd1;

    always_comb begin
        w_next_pc = w_pc_plus4;
        case (pc_src_i)
            SRC_SEQ:    w_next_pc = w_pc_plus4;
            SRC_BRANCH: w_next_pc = branch_tgt_i;
            SRC_JALR:   w_next_pc = w_jalr_aligned;
            default:    w_next_pc = w_pc_plus4;
        endcase
    end

    assign w_misaligned = (w_next_pc[1:0] != 2'b00);
    assign w_out_range  = (w_next_pc >= IMEM_LIMIT);
    assign w_advance    = (r_state == ST_RUN) && !stall_i;
    assign w_fault      = w_advance && (w_misaligned || w_out_range);

    // Misalignment outranks range when a target is both.
    always_comb begin
        w_fault_cause = CAUSE_NONE;
        if (w_misaligned) begin
            w_fault_cause = CAUSE_MISALIGN;
        end else if (w_out_range) begin
            w_fault_cause = CAUSE_OUT_RANGE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_BOOT;
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN:  r_state <= w_fault ? ST_HALT : ST_RUN;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    // A faulting instruction still retires, but the PC stays on it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc      <= RESET_VECTOR;
            r_instret <= 32'd0;
        end else if (w_advance) begin
            r_instret <= r_instret + 32'd1;
            if (!w_fault) begin
                r_pc <= w_next_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_trap  <= 1'b0;
            r_cause <= CAUSE_NONE;
        end else if (w_fault && !r_trap) begin
            r_trap  <= 1'b1;
            r_cause <= w_fault_cause;
        end
    end

    assign pc_o          = r_pc;
    assign pc_plus4_o    = w_pc_plus4;
    assign instr_valid_o = w_advance;
    assign instr_o       = w_advance ? instr_i : NOP_INSTR;
    assign trap_o        = r_trap;
    assign trap_cause_o  = r_cause;
    assign instret_o     = r_instret;
    assign state_o       = r_state;

endmodule
